// File: rtl/gpf_sequencer.sv
// Sequencing core of the general-purpose FSM controller: program store, state and
// output registers, countdown timer, sensor synchronisers and the serial program loader.
module gpf_sequencer #(
    parameter int IN_W  = 4,
    parameter int ST_W  = 4,
    parameter int OUT_W = 8,
    parameter int CNT_W = 8,
    parameter int ILEN  = 24
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Load_i,
    input  logic             Run_i,
    input  logic             SDat_i,
    input  logic             SVal_i,
    input  logic             Tick_i,
    input  logic [IN_W-1:0]  Sens_ai,
    input  logic [ST_W-1:0]  State_ns_i,
    input  logic [OUT_W-1:0] NextOut_i,
    input  logic             Trig_i,
    input  logic [CNT_W-1:0] Time_i,
    output logic [ILEN-1:0]  Instr_o,
    output logic [ST_W-1:0]  State_o,
    output logic [IN_W-1:0]  Sens_o,
    output logic             TimeOut_o,
    output logic [OUT_W-1:0] Q_o,
    output logic [1:0]       Mode_o
);

    localparam int BCW   = $clog2(ILEN);
    localparam int DEPTH = 2 ** ST_W;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_RUN  = 2'b10
    } mode_e;

    mode_e            mode_q, mode_d;
    logic [ST_W-1:0]  state_q;
    logic [OUT_W-1:0] out_q;
    logic [CNT_W-1:0] count_q;
    logic             armed_q;
    logic [IN_W-1:0]  sync1_q, sync2_q;
    logic [ILEN-1:0]  shift_q;
    logic [BCW-1:0]   bitcnt_q;
    logic [ST_W-1:0]  wptr_q;
    logic [ILEN-1:0]  mem [DEPTH];

    logic run_stay;
    logic load_bit;
    logic word_done;

    // Load_i outranks Run_i in every mode.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_IDLE: begin
                if (Load_i)     mode_d = MODE_LOAD;
                else if (Run_i) mode_d = MODE_RUN;
            end
            MODE_LOAD: begin
                if (!Load_i)    mode_d = MODE_IDLE;
            end
            MODE_RUN: begin
                if (Load_i)     mode_d = MODE_LOAD;
                else if (!Run_i) mode_d = MODE_IDLE;
            end
            default:            mode_d = MODE_IDLE;
        endcase
    end

    assign run_stay  = (mode_q == MODE_RUN) && (mode_d == MODE_RUN);
    assign load_bit  = (mode_q == MODE_LOAD) && Load_i && SVal_i;
    assign word_done = load_bit && (bitcnt_q == BCW'(ILEN - 1));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            mode_q   <= MODE_IDLE;
            state_q  <= '0;
            out_q    <= '0;
            count_q  <= '0;
            armed_q  <= 1'b0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            shift_q  <= '0;
            bitcnt_q <= '0;
            wptr_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            sync1_q <= Sens_ai;
            sync2_q <= sync1_q;

            // The decoder result is only taken while RUN persists; any exit zeroes state and outputs.
            if (run_stay) begin
                state_q <= State_ns_i;
                out_q   <= NextOut_i;
            end else begin
                state_q <= '0;
                out_q   <= '0;
            end

            if (!run_stay) begin
                count_q <= '0;
                armed_q <= 1'b0;
            end else if (Trig_i) begin
                count_q <= Time_i;
                armed_q <= 1'b1;
            end else if (armed_q && (count_q != '0) && Tick_i) begin
                count_q <= count_q - CNT_W'(1);
            end

            if ((mode_q != MODE_LOAD) && (mode_d == MODE_LOAD)) begin
                bitcnt_q <= '0;
                wptr_q   <= '0;
            end else if (load_bit) begin
                shift_q <= {shift_q[ILEN-2:0], SDat_i};
                if (word_done) begin
                    bitcnt_q <= '0;
                    wptr_q   <= wptr_q + ST_W'(1);
                end else begin
                    bitcnt_q <= bitcnt_q + BCW'(1);
                end
            end
        end
    end

    // NOTE: the program store has no reset on purpose so a loaded program survives Rst.
    always_ff @(posedge Clk) begin
        if (word_done)
            mem[wptr_q] <= {shift_q[ILEN-2:0], SDat_i};
    end

    assign Instr_o   = mem[state_q];
    assign State_o   = state_q;
    assign Q_o       = out_q;
    assign Sens_o    = sync2_q;
    assign TimeOut_o = armed_q && (count_q == '0);
    assign Mode_o    = mode_q;

endmodule

// File: tb/tb_gpf_sequencer.sv
// Directed self-checking bench for gpf_sequencer: load, partial load, run stepping,
// timer, reset mid-run, mode priority and sensor synchroniser latency.
module tb_gpf_sequencer;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Load_i = 1'b0, Run_i = 1'b0, SDat_i = 1'b0, SVal_i = 1'b0, Tick_i = 1'b0;
    logic [3:0]  Sens_ai = '0;
    logic [3:0]  State_ns_i;
    logic [7:0]  NextOut_i;
    logic        Trig_i = 1'b0;
    logic [7:0]  Time_i = '0;
    logic [23:0] Instr_o;
    logic [3:0]  State_o;
    logic [3:0]  Sens_o;
    logic        TimeOut_o;
    logic [7:0]  Q_o;
    logic [1:0]  Mode_o;

    logic        stub_en = 1'b0;
    logic [3:0]  ns_drv = '0;
    logic [7:0]  out_drv = '0;

    int total = 0;
    int bad   = 0;

    gpf_sequencer dut (
        .Clk(Clk), .Rst(Rst), .Load_i(Load_i), .Run_i(Run_i), .SDat_i(SDat_i),
        .SVal_i(SVal_i), .Tick_i(Tick_i), .Sens_ai(Sens_ai), .State_ns_i(State_ns_i),
        .NextOut_i(NextOut_i), .Trig_i(Trig_i), .Time_i(Time_i), .Instr_o(Instr_o),
        .State_o(State_o), .Sens_o(Sens_o), .TimeOut_o(TimeOut_o), .Q_o(Q_o), .Mode_o(Mode_o)
    );

    // Decoder stub: either counts state up by one with the old state as output, or drives fixed values.
    assign State_ns_i = stub_en ? State_o + 4'd1 : ns_drv;
    assign NextOut_i  = stub_en ? {4'b0, State_o} : out_drv;

    always #5 Clk = ~Clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [47:0] stream;
        stream = {24'hABCDEF, 24'h123456};

        tick(2);
        check("rst_mode", Mode_o, 2'b00);
        check("rst_state", State_o, 0);
        check("rst_q", Q_o, 0);
        check("rst_timeout", TimeOut_o, 0);
        check("rst_sens", Sens_o, 0);
        Rst = 1'b0;

        Load_i = 1'b1; Run_i = 1'b1;
        tick();
        check("prio_load", Mode_o, 2'b01);
        Run_i = 1'b0;
        for (int i = 0; i < 48; i++) begin
            SVal_i = 1'b1; SDat_i = stream[47-i];
            tick();
            if (i % 5 == 4) begin
                SVal_i = 1'b0; SDat_i = ~SDat_i;
                tick();
            end
        end
        SVal_i = 1'b0; Load_i = 1'b0;
        tick();
        check("load_exit_mode", Mode_o, 2'b00);
        check("load_word0", Instr_o, 24'hABCDEF);

        Load_i = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            SVal_i = 1'b1; SDat_i = 1'b1;
            tick();
        end
        SVal_i = 1'b0; Load_i = 1'b0;
        tick();
        check("partial_mode", Mode_o, 2'b00);
        check("partial_word0", Instr_o, 24'hABCDEF);

        stub_en = 1'b1; Run_i = 1'b1;
        tick();
        check("run_mode", Mode_o, 2'b10);
        check("run_state0", State_o, 0);
        check("run_q0", Q_o, 0);
        for (int k = 1; k <= 17; k++) begin
            tick();
            check("run_state", State_o, k % 16);
            check("run_q", Q_o, (k - 1) % 16);
            if (k == 1) check("run_word1", Instr_o, 24'h123456);
        end
        Run_i = 1'b0;
        tick();
        check("run_exit_mode", Mode_o, 2'b00);
        check("run_exit_state", State_o, 0);
        check("run_exit_q", Q_o, 0);

        Run_i = 1'b1;
        tick();
        Tick_i = 1'b1; Trig_i = 1'b1; Time_i = 8'd3;
        tick();
        Trig_i = 1'b0;
        check("tmr_c3", TimeOut_o, 0);
        tick(); check("tmr_c2", TimeOut_o, 0);
        tick(); check("tmr_c1", TimeOut_o, 0);
        tick(); check("tmr_expire", TimeOut_o, 1);
        tick(); check("tmr_hold", TimeOut_o, 1);
        Trig_i = 1'b1; Time_i = 8'd2;
        tick();
        Trig_i = 1'b0; Tick_i = 1'b0;
        check("tmr_retrig", TimeOut_o, 0);
        tick(2); check("tmr_frozen", TimeOut_o, 0);
        Tick_i = 1'b1;
        tick(); check("tmr_r1", TimeOut_o, 0);
        tick(); check("tmr_r0", TimeOut_o, 1);
        Trig_i = 1'b1; Time_i = 8'd5;
        tick(); check("tmr_t5", TimeOut_o, 0);
        Time_i = 8'd0;
        tick();
        Trig_i = 1'b0;
        check("tmr_t0", TimeOut_o, 1);
        Run_i = 1'b0;
        tick();
        check("tmr_leave", TimeOut_o, 0);

        stub_en = 1'b0; ns_drv = 4'd5; out_drv = 8'hA5; Tick_i = 1'b0;
        Run_i = 1'b1;
        tick();
        Trig_i = 1'b1; Time_i = 8'd7;
        tick();
        Trig_i = 1'b0;
        check("mid_state", State_o, 5);
        check("mid_q", Q_o, 8'hA5);
        check("mid_timeout", TimeOut_o, 0);
        Rst = 1'b1; Run_i = 1'b0;
        tick();
        check("mid_rst_mode", Mode_o, 2'b00);
        check("mid_rst_state", State_o, 0);
        check("mid_rst_q", Q_o, 0);
        check("mid_rst_timeout", TimeOut_o, 0);
        check("mid_rst_word0", Instr_o, 24'hABCDEF);
        Rst = 1'b0;

        Sens_ai = 4'h3;
        tick(); check("sync_1cyc", Sens_o, 4'h0);
        tick(); check("sync_2cyc", Sens_o, 4'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpf_sequencer.md
Name: gpf_sequencer

Overview:
- Sequencing core of the general-purpose FSM controller.
- Holds the program store, state register, countdown timer, input synchronisers and registered outputs.
- Presents the current instruction, state, synchronised sensors and timeout flag to the combinational decoder, and registers the decoder's next-state/output/timer results each cycle.
- Also runs the serial loader that writes the program store.

Parameters:
- IN_W, 4, sensor input count
- ST_W, 4, state/address width; program store depth = 2**ST_W words
- OUT_W, 8, control output width
- CNT_W, 8, timer width
- ILEN, 24, instruction word width

Ports:
- Clk  in  1  system clock
- Rst  in  1  synchronous active-high reset
- Load_i  in  1  program-load mode request
- Run_i  in  1  run enable
- SDat_i  in  1  serial program data, MSB first
- SVal_i  in  1  SDat_i valid strobe, one bit per cycle when high
- Tick_i  in  1  timer decrement enable (prescaler tick)
- Sens_ai  in  IN_W  asynchronous sensor inputs
- State_ns_i  in  ST_W  next state from decoder
- NextOut_i  in  OUT_W  next outputs from decoder
- Trig_i  in  1  timer load request from decoder
- Time_i  in  CNT_W  timer load value from decoder
- Instr_o  out  ILEN  program word at current state
- State_o  out  ST_W  current state register
- Sens_o  out  IN_W  synchronised sensors
- TimeOut_o  out  1  timer expired flag
- Q_o  out  OUT_W  registered control outputs
- Mode_o  out  2  00 IDLE, 01 LOAD, 10 RUN

Behaviour:
- One clock (Clk). Reset (Rst) is synchronous and active-high.
- Reset values:
  - Mode=IDLE.
  - State_o, Q_o, timer count, armed bit, shift register, bit counter, write pointer, sync flops all 0.
  - TimeOut_o=0.
  - The program store is NOT reset and survives Rst.
- Sensors: two-flop synchroniser. Sens_o lags Sens_ai by 2 cycles.
- Instr_o = mem[State_o]. This is an asynchronous read, valid in the same cycle State_o changes.
- Mode FSM, evaluated every cycle. Load_i has priority over Run_i.
  - IDLE:
    - Load_i=1 -> LOAD; clear bit counter and write pointer.
    - else Run_i=1 -> RUN.
  - LOAD:
    - On SVal_i=1: shift = {shift[ILEN-2:0], SDat_i}; bitcnt++.
    - When bitcnt reaches ILEN-1 and SVal_i=1: write the completed word to mem[wptr] on that edge; wptr++ (wraps at 2**ST_W); bitcnt=0.
    - Load_i=0 -> IDLE. A partial word is discarded and memory is unchanged.
  - RUN:
    - Each cycle: State_o <= State_ns_i; Q_o <= NextOut_i.
    - Run_i=0 -> IDLE with State_o=0 and Q_o=0 next cycle.
    - Load_i=1 -> LOAD with State_o=0 and Q_o=0.
  - In IDLE and LOAD: State_o and Q_o are held at 0, and Trig_i is ignored.
- Timer:
  - In RUN with Trig_i=1: count <= Time_i; armed <= 1. This takes precedence over a decrement in the same cycle.
  - Otherwise, if armed, count != 0 and Tick_i=1: count--.
  - TimeOut_o = armed & (count==0), combinational from registers.
  - Trig_i with Time_i=0 -> TimeOut_o=1 the next cycle.
  - TimeOut_o stays high until the next Trig_i or leaving RUN. Leaving RUN clears armed and count.
- Latency:
  - Decoder result is visible on State_o/Q_o one cycle after it is presented.
  - A sensor change affects State_o no earlier than 3 cycles later.
- Wrap: State_ns_i = 2**ST_W-1 followed by +1 wraps to 0; this is handled entirely by the decoder's width. No special case here.

Test Plan:
- Reset mid-RUN: State_o=5, Q_o=8'hA5, count=7, Rst pulse -> next cycle all 0, Mode=IDLE, program words still readable unchanged.
- Load: Load_i=1, shift 48 bits = 24'hABCDEF then 24'h123456 with SVal_i gaps -> mem[0]=ABCDEF, mem[1]=123456; with State_o=0 in IDLE, Instr_o=ABCDEF.
- Partial load: 10 bits then Load_i=0 -> Mode=IDLE next cycle, mem[0] unchanged.
- Run stepping: Run_i=1, decoder stub returns State_ns_i=State_o+1, NextOut_i=State_o -> State_o counts 0..15, wraps to 0; Q_o trails by one value.
- Timer: Trig_i with Time_i=3, Tick_i=1 constant -> TimeOut_o low 3 cycles, high on the 4th cycle after the load edge. Retrigger while high clears it. Tick_i=0 freezes count. Time_i=0 gives timeout after 1 cycle.
- Priority/sync: Load_i and Run_i both raised in IDLE -> LOAD. Sens_ai 0->4'h3 -> Sens_o=4'h3 exactly 2 cycles later.
